// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
//   Types and constants shared between the call-request front end
//   (call_request_latch) and the car controller (elevator_fsm).
//   NUM_FLOORS : number of floors, which is also the number of buttons per panel
//   FLOOR_W    : width of a floor index
//   floor_t    : a floor index
//   req_vec_t  : one bit per floor (requests, lamps, masks)
// -----------------------------------------------------------------------------
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  typedef logic [FLOOR_W-1:0]    floor_t;
  typedef logic [NUM_FLOORS-1:0] req_vec_t;

  // One-hot mask for floor f. An index beyond the last floor is possible when
  // NUM_FLOORS is not a power of two; such an index yields an all-zero mask.
  function automatic req_vec_t floor_onehot(input floor_t f);
    req_vec_t m;
    m = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (f == floor_t'(k)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/call_request_latch_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw push button. A 2-flop synchroniser feeds a debouncer
//   that accepts a level change only after DEBOUNCE_CYCLES consecutive
//   synchronised samples disagree with the current debounced level. A press
//   event is a registered one-cycle pulse on the debounced 0->1 transition.
//   Release produces no event.
// Ports
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-low
//   raw   in  raw button level, asynchronous, 1 = pressed
//   press out one-cycle pulse per accepted press
//   level out debounced button level
// Parameters
//   DEBOUNCE_CYCLES  stable samples needed to accept a change (>= 2)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press,
  output logic level
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: every flop here uses <= so all of them sample the values from
  // before the edge; blocking assignments would collapse the synchroniser
  // into a single stage and break the counter/level ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      deb       <= 1'b0;
      deb_d     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      deb_d     <= deb;
      // Registered so that the press reaches the request latch one cycle
      // after deb rises, fixing the raw-to-request latency.
      press     <= deb & ~deb_d;

      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This sample is the last of the run of disagreeing samples.
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = deb;

endmodule

// File: rtl/call_request_latch.sv
// -----------------------------------------------------------------------------
// call_request_latch
//   Front end of the elevator controller. Debounces every hall and cabin
//   button. Latches each accepted press as a pending request. Clears the
//   requests of the floor being serviced (door open at current_floor). The
//   pending vectors are held levels into elevator_fsm and also drive the
//   button lamps.
// Ports
//   clk            in  system clock, rising edge
//   rst            in  asynchronous reset, active-low
//   hall_btn_raw   in  raw hall call buttons, 1 = pressed
//   cab_btn_raw    in  raw cabin call buttons, 1 = pressed
//   current_floor  in  car position
//   door_open      in  door-open flag; services current_floor while high
//   f_req          out pending hall requests / hall lamps
//   c_req          out pending cabin requests / cabin lamps
//   req_any        out OR of all pending requests
// Configuration
//   CAB_CANCEL_EN  when defined, a press on an already-pending cabin button
//                  cancels that request. Hall requests are never cancellable.
//                  Servicing a floor still wins over a same-cycle press.
// -----------------------------------------------------------------------------
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_btn_raw,
  input  logic [NUM_FLOORS-1:0] cab_btn_raw,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  output logic [NUM_FLOORS-1:0] f_req,
  output logic [NUM_FLOORS-1:0] c_req,
  output logic                  req_any
);

  req_vec_t hall_press;
  req_vec_t cab_press;
  req_vec_t hall_level;
  req_vec_t cab_level;
  req_vec_t svc;
  req_vec_t f_next;
  req_vec_t c_next;

  for (genvar k = 0; k < NUM_FLOORS; k++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_hall (
      .clk   (clk),
      .rst   (rst),
      .raw   (hall_btn_raw[k]),
      .press (hall_press[k]),
      .level (hall_level[k])
    );

    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cab (
      .clk   (clk),
      .rst   (rst),
      .raw   (cab_btn_raw[k]),
      .press (cab_press[k]),
      .level (cab_level[k])
    );
  end

  // NOTE: svc is assigned on every path before it is used, so this block
  // stays purely combinational and infers no latch.
  always_comb begin
    svc    = door_open ? floor_onehot(current_floor) : '0;
    // Masking with ~svc last gives service priority over a same-cycle press.
    f_next = (f_req | hall_press) & ~svc;
`ifdef CAB_CANCEL_EN
    // A press on a pending cabin call toggles it off (passenger cancel).
    c_next = (c_req ^ cab_press) & ~svc;
`else
    c_next = (c_req | cab_press) & ~svc;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_req <= '0;
      c_req <= '0;
    end else begin
      f_req <= f_next;
      c_req <= c_next;
    end
  end

  // Derived only from flops, so it is glitch-free in practice.
  assign req_any = |{f_req, c_req};

  // The debounced levels are not needed by the latch. Folding them into an
  // unused reduction keeps them visible for debug.
  logic level_unused;
  assign level_unused = ^{hall_level, cab_level};

endmodule

// File: tb/tb_call_request_latch.sv
// -----------------------------------------------------------------------------
// tb_call_request_latch
//   Self-checking bench for call_request_latch. It uses a table of directed
//   steps with hand-derived expected values, hand-written reset sequences, and
//   a randomized phase compared against a history-window reference model.
// -----------------------------------------------------------------------------
module tb_call_request_latch;
  import elevator_pkg::*;

  localparam int D  = 4;
  localparam int NF = NUM_FLOORS;
  localparam int NB = 2 * NF;
`ifdef CAB_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] hall_btn_raw;
  logic [NF-1:0] cab_btn_raw;
  floor_t        current_floor;
  logic          door_open;
  logic [NF-1:0] f_req;
  logic [NF-1:0] c_req;
  logic          req_any;

  int checks   = 0;
  int failures = 0;

  call_request_latch #(.DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .hall_btn_raw  (hall_btn_raw),
    .cab_btn_raw   (cab_btn_raw),
    .current_floor (current_floor),
    .door_open     (door_open),
    .f_req         (f_req),
    .c_req         (c_req),
    .req_any       (req_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A button's debounced level flips at an edge when the raw samples taken
  // 2..D+1 edges earlier (what the synchroniser delivers) all disagree with
  // it. A rise becomes a request update two edges later.
  logic [NB-1:0] samp_q[$];
  logic [NB-1:0] deb_m, rose1, rose2;
  logic [NF-1:0] f_m, c_m;

  task automatic model_reset();
    samp_q.delete();
    deb_m = '0; rose1 = '0; rose2 = '0;
    f_m = '0; c_m = '0;
  endtask

  function automatic logic [NB-1:0] sample_at(input int age);
    return (age < samp_q.size()) ? samp_q[age] : '0;
  endfunction

  task automatic model_step();
    logic [NB-1:0] press, newdeb, s;
    logic [NF-1:0] svc;
    bit            all_differ;
    samp_q.push_front({cab_btn_raw, hall_btn_raw});
    if (samp_q.size() > D + 2) void'(samp_q.pop_back());
    press = rose2;
    svc = '0;
    if (door_open && int'(current_floor) < NF) svc[current_floor] = 1'b1;
    for (int k = 0; k < NF; k++) begin
      if (svc[k]) begin
        f_m[k] = 1'b0;
        c_m[k] = 1'b0;
      end else begin
        if (press[k])      f_m[k] = 1'b1;
        if (press[NF + k]) c_m[k] = CANCEL ? ~c_m[k] : 1'b1;
      end
    end
    for (int b = 0; b < NB; b++) begin
      all_differ = 1'b1;
      for (int a = 2; a < D + 2; a++) begin
        s = sample_at(a);
        if (s[b] == deb_m[b]) all_differ = 1'b0;
      end
      newdeb[b] = all_differ ? ~deb_m[b] : deb_m[b];
    end
    rose2 = rose1;
    rose1 = newdeb & ~deb_m;
    deb_m = newdeb;
  endtask

  // One clock edge: the model sees the same pre-edge inputs as the DUT.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string      name;
    logic [3:0] hall;
    logic [3:0] cab;
    logic [1:0] floor;
    logic       door;
    int         cycles;
    logic [3:0] f;
    logic [3:0] c;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [3:0] h, input logic [3:0] cb,
                              input logic [1:0] fl, input logic d, input int cy,
                              input logic [3:0] ef, input logic [3:0] ec, input logic ea);
    vec_t v;
    v.name = n; v.hall = h; v.cab = cb; v.floor = fl; v.door = d; v.cycles = cy;
    v.f = ef; v.c = ec; v.any = ea;
    return v;
  endfunction

  initial begin
    logic [3:0] c_cancel;
    c_cancel = CANCEL ? 4'b0000 : 4'b0010;

    vecs.push_back(mk("glitch_hi",   4'b0010, 4'b0000, 2'd0, 1'b0,  3, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk("glitch_lo",   4'b0000, 4'b0000, 2'd0, 1'b0, 10, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk("press_pre7",  4'b0100, 4'b0000, 2'd0, 1'b0,  7, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk("press_at7",   4'b0100, 4'b0000, 2'd0, 1'b0,  1, 4'b0100, 4'b0000, 1'b1));
    vecs.push_back(mk("press_hold",  4'b0100, 4'b0000, 2'd0, 1'b0, 12, 4'b0100, 4'b0000, 1'b1));
    vecs.push_back(mk("press_rel",   4'b0000, 4'b0000, 2'd0, 1'b0, 10, 4'b0100, 4'b0000, 1'b1));
    vecs.push_back(mk("cab3_set",    4'b0000, 4'b1000, 2'd0, 1'b0,  8, 4'b0100, 4'b1000, 1'b1));
    vecs.push_back(mk("cab3_rel",    4'b0000, 4'b0000, 2'd0, 1'b0, 10, 4'b0100, 4'b1000, 1'b1));
    vecs.push_back(mk("service2",    4'b0000, 4'b0000, 2'd2, 1'b1,  1, 4'b0000, 4'b1000, 1'b1));
    vecs.push_back(mk("door_close",  4'b0000, 4'b0000, 2'd2, 1'b0,  1, 4'b0000, 4'b1000, 1'b1));
    vecs.push_back(mk("collide",     4'b0000, 4'b1001, 2'd3, 1'b1,  8, 4'b0000, 4'b0001, 1'b1));
    vecs.push_back(mk("collide_rel", 4'b0000, 4'b0000, 2'd3, 1'b0, 10, 4'b0000, 4'b0001, 1'b1));
    vecs.push_back(mk("service0",    4'b0000, 4'b0000, 2'd0, 1'b1,  1, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk("cab1_set",    4'b0000, 4'b0010, 2'd0, 1'b0,  8, 4'b0000, 4'b0010, 1'b1));
    vecs.push_back(mk("cab1_rel",    4'b0000, 4'b0000, 2'd0, 1'b0, 10, 4'b0000, 4'b0010, 1'b1));
    vecs.push_back(mk("cab1_repress",4'b0000, 4'b0010, 2'd0, 1'b0,  8, 4'b0000, c_cancel, |c_cancel));
    vecs.push_back(mk("cab1_rel2",   4'b0000, 4'b0000, 2'd0, 1'b0, 10, 4'b0000, c_cancel, |c_cancel));

    // ---- reset with every button held, then re-qualify from scratch ----
    rst = 1'b0; hall_btn_raw = '1; cab_btn_raw = '1; current_floor = '0; door_open = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("reset f_req",   8'(f_req),   8'h0);
    check("reset c_req",   8'(c_req),   8'h0);
    check("reset req_any", 8'(req_any), 8'h0);
    model_reset();
    rst = 1'b1;
    ticks(7);
    check("held edge6 f_req", 8'(f_req), 8'h0);
    tick();
    check("held edge7 f_req", 8'(f_req), 8'hF);
    check("held edge7 c_req", 8'(c_req), 8'hF);
    check("held edge7 any",   8'(req_any), 8'h1);

    // Release all buttons, then service every floor in turn.
    hall_btn_raw = '0; cab_btn_raw = '0;
    ticks(10);
    door_open = 1'b1;
    for (int k = 0; k < NF; k++) begin
      current_floor = floor_t'(k);
      tick();
    end
    door_open = 1'b0; current_floor = '0;
    tick();
    check("cleared f_req", 8'(f_req), 8'h0);
    check("cleared c_req", 8'(c_req), 8'h0);

    // ---- directed table ----
    foreach (vecs[i]) begin
      hall_btn_raw  = vecs[i].hall;
      cab_btn_raw   = vecs[i].cab;
      current_floor = vecs[i].floor;
      door_open     = vecs[i].door;
      ticks(vecs[i].cycles);
      check({vecs[i].name, " f_req"},   8'(f_req),   8'(vecs[i].f));
      check({vecs[i].name, " c_req"},   8'(c_req),   8'(vecs[i].c));
      check({vecs[i].name, " req_any"}, 8'(req_any), 8'(vecs[i].any));
    end

    // Empty any cabin request left by the cancel step.
    current_floor = 2'd1; door_open = 1'b1;
    tick();
    door_open = 1'b0; current_floor = '0;

    // ---- reset in the middle of a press discards it ----
    hall_btn_raw = 4'b0001;
    ticks(4);
    rst = 1'b0;
    ticks(2);
    check("midreset f_req", 8'(f_req), 8'h0);
    rst = 1'b1;
    ticks(7);
    check("midreset edge6 f_req", 8'(f_req), 8'h0);
    tick();
    check("midreset edge7 f_req", 8'(f_req), 8'h1);
    hall_btn_raw = '0;
    ticks(10);
    door_open = 1'b1;
    tick();
    door_open = 1'b0;
    tick();
    check("midreset cleared", 8'(f_req), 8'h0);

    // ---- randomized phase against the model ----
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < NF; b++) begin
        if ($urandom_range(15) == 0) hall_btn_raw[b] = ~hall_btn_raw[b];
        if ($urandom_range(15) == 0) cab_btn_raw[b]  = ~cab_btn_raw[b];
      end
      door_open     = ($urandom_range(7) == 0);
      current_floor = floor_t'($urandom_range(NF - 1));
      tick();
      check("rand vectors", {f_req, c_req}, {f_m, c_m});
      check("rand req_any", 8'(req_any), 8'(|{f_m, c_m}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
